// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, control codes and arbiter FSM states.
package alu_pkg;

  localparam int XLEN       = 32;
  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b1001;
  localparam logic [ALU_CTRL_W-1:0] ALU_LUI  = 4'b1010;
  localparam logic [ALU_CTRL_W-1:0] ALU_CTRL_MAX = 4'b1010;

  // IDLE: no response held; RESP: response held for the current owner
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU. Codes above ALU_CTRL_MAX yield zero and flag illegal.
module alu
  import alu_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [ALU_CTRL_W-1:0] ctrl_i,
  input  logic [W-1:0]          a_i,
  input  logic [W-1:0]          b_i,
  output logic [W-1:0]          result_o,
  output logic                  zero_o,
  output logic                  illegal_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  // Operation decode; unsupported codes fall through to the illegal default
  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (ctrl_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = W'($signed(a_i) >>> shamt);
      ALU_SLT:  result_o = {{(W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {{(W-1){1'b0}}, (a_i < b_i)};
      ALU_LUI:  result_o = b_i;
      default:  illegal_o = 1'b1;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping mod N.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  // Scan N positions starting at ptr; the first hit wins
  always_comb begin
    int s;
    s         = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    if (en_i) begin
      for (int k = 0; k < N; k++) begin
        s = int'(ptr_i) + k;
        if (s >= N) s = s - N;
        if (!gnt_vld_o && req_i[PW'(s)]) begin
          gnt_o[PW'(s)] = 1'b1;
          gnt_idx_o     = PW'(s);
          gnt_vld_o     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin grant and a
// single registered response slot. Back-to-back ops issue with no bubble
// when the owner consumes its response in the same cycle.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = alu_pkg::XLEN,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0][ALU_CTRL_W-1:0]   req_ctrl,
  input  logic [NUM_REQ-1:0][XLEN-1:0]         req_a,
  input  logic [NUM_REQ-1:0][XLEN-1:0]         req_b,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  input  logic [NUM_REQ-1:0]                   rsp_ready,
  output logic [XLEN-1:0]                      rsp_result,
  output logic                                 rsp_zero,
  output logic                                 rsp_illegal
);

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            zero_q, zero_d;
  logic            ill_q, ill_d;

  logic            can_accept;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_vld;
  logic [XLEN-1:0] alu_res;
  logic            alu_zero, alu_ill;

  // Slot is free when empty or when the owner drains it this cycle; reset blocks accepts
  assign can_accept = rst_n & ((state_q == ST_IDLE) | rsp_ready[owner_q]);

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .en_i      (can_accept),
    .gnt_o     (req_ready),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  alu #(.W(XLEN)) u_alu (
    .ctrl_i    (req_ctrl[gnt_idx]),
    .a_i       (req_a[gnt_idx]),
    .b_i       (req_b[gnt_idx]),
    .result_o  (alu_res),
    .zero_o    (alu_zero),
    .illegal_o (alu_ill)
  );

  // Next state: a new accept always wins the response slot over a plain drain
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    if (gnt_vld) begin
      state_d = ST_RESP;
      owner_d = gnt_idx;
      ptr_d   = (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + PW'(1);
      res_d   = alu_res;
      zero_d  = alu_zero;
      ill_d   = alu_ill;
    end else if (state_q == ST_RESP && rsp_ready[owner_q]) begin
      state_d = ST_IDLE;
    end
  end

  // State and response registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end

  // One-hot response valid toward the owner while a response is held
  always_comb begin
    rsp_valid = '0;
    if (state_q == ST_RESP) rsp_valid[owner_q] = 1'b1;
  end

  assign rsp_result  = res_q;
  assign rsp_zero    = zero_q;
  assign rsp_illegal = ill_q;

endmodule
